sd_line_bridge: RTL and testbench
=================================

Name: sd_line_bridge

Overview:
- Line-level responder on the SD side of the cache.
- Accepts one request per transaction from the cache: a read (cmd=0) or a write-back (cmd=1) of one WIDTH-bit line.
- Converts each request into a block command plus a byte stream for the SD block engine, which handles the SPI/SD protocol.
- For reads, reassembles the returned bytes into a line and hands it back to the cache. Retries failed blocks a bounded number of times.

Parameters:
- ADDR, 32, byte-address width of requests and block-address width.
- CMD, 1, command width; bit 0: 1=write, 0=read.
- WIDTH, 4096, line width in bits. WIDTH/8 bytes per line; one line = one SD block.
- RETRIES, 2, extra attempts after a failed block (0..7).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  cache request valid
- req_ready  out  1  bridge can accept a request
- req_addr  in  ADDR  byte address (line-aligned; low OFFSET bits ignored)
- req_data  in  WIDTH  write-back line
- req_cmd  in  CMD  1=write, 0=read
- rsp_valid  out  1  read line available
- rsp_ready  in  1  cache accepts line
- rsp_data  out  WIDTH  read line; byte i at bits [8i+7:8i]
- blk_valid  out  1  block command valid
- blk_ready  in  1  engine accepts command
- blk_addr  out  ADDR  block number = req_addr >> OFFSET, OFFSET = log2(WIDTH/8)
- blk_wr  out  1  1=write block, 0=read block
- wr_valid  out  1  write byte valid
- wr_ready  in  1  engine takes byte
- wr_byte  out  8  write byte
- rd_valid  in  1  read byte valid
- rd_ready  out  1  bridge takes byte
- rd_byte  in  8  read byte
- blk_done  in  1  single-cycle end-of-block pulse from engine
- blk_err  in  1  qualifies blk_done: block failed
- err_flag  out  1  sticky: a request failed after all retries

Behaviour:
- Handshake rule: a transfer occurs when valid & ready are both high at a rising edge. Valid outputs, once raised, hold with stable data until the transfer completes.
- States: IDLE, ISSUE, WR_STREAM, RD_STREAM, WAIT_DONE, RESPOND.
- Reset: state=IDLE. Byte count, retry count and err_flag=0. rsp_data, blk_addr, blk_wr and the line buffer=0. All valid/ready outputs 0 except req_ready=1.
- Reset mid-operation abandons the transfer with no further bytes or commands; the engine is reset by the same reset.
- IDLE:
  - req_ready=1.
  - On request handshake: latch blk_addr, blk_wr=req_cmd[0], and line buffer = req_data (write) or unchanged (read). Retry count=0; go to ISSUE.
  - blk_valid rises the cycle after acceptance.
- ISSUE:
  - blk_valid=1.
  - On blk handshake: byte count=0; go to WR_STREAM if blk_wr, else RD_STREAM.
- WR_STREAM:
  - wr_valid=1; wr_byte = buffer[8*count+7 : 8*count].
  - Each handshake increments count.
  - Handshake at count=WIDTH/8-1 goes to WAIT_DONE.
- RD_STREAM:
  - rd_ready=1.
  - Each handshake writes rd_byte into buffer byte[count] and increments count.
  - Last byte goes to WAIT_DONE.
- blk_done during WR_STREAM/RD_STREAM (early end):
  - Treated as a failure regardless of blk_err.
  - Streaming stops the same cycle and failure handling below applies.
- WAIT_DONE:
  - Waits for blk_done.
  - Success (blk_err=0): read goes to RESPOND with rsp_data=buffer; write goes to IDLE.
- Failure handling:
  - Retry count < RETRIES: increment it, go to ISSUE; same address, write buffer unchanged.
  - Retries exhausted: set err_flag. Read still goes to RESPOND with the partial buffer contents; write goes to IDLE.
- RESPOND:
  - rsp_valid=1.
  - On rsp handshake go to IDLE; req_ready rises the next cycle.
- Write requests never produce rsp_valid.
- Only one outstanding request; req_ready=0 outside IDLE.
- Minimum latency, read request to rsp_valid: 1 (ISSUE) + 1 (command) + WIDTH/8 bytes + 1 (done) cycles.
- blk_done pulses while in IDLE/ISSUE/RESPOND are ignored.

Test Plan:
- Read, addr 0x0000_0400, engine returns bytes 0x00..0xFF,0x00..0xFF with no stalls:
  - blk_addr=2, blk_wr=0.
  - rsp_data byte i = i mod 256.
  - rsp_valid 515 cycles after acceptance; err_flag=0.
- Write, addr 0x0000_0600, req_data byte i = ~i, wr_ready toggling every cycle:
  - blk_addr=3, blk_wr=1.
  - 512 bytes emitted in order, each 0xFF-(i mod 256), held stable through stalls.
  - No rsp_valid; req_ready returns after blk_done.
- Read with first blk_done carrying blk_err=1, second clean:
  - Exactly two blk handshakes, same blk_addr.
  - Second attempt's data returned; err_flag=0.
- Write failing 3 times with RETRIES=2:
  - Three command issues, then err_flag=1 (sticky), IDLE.
  - Next read completes normally with err_flag still 1.
- rsp_ready held low 10 cycles: rsp_valid/rsp_data stable, req_ready=0 throughout. Then early blk_done with no error at byte 100 of a read: counted as a failure and retried.
- Reset asserted at byte 200 of a write:
  - Next cycle wr_valid=0, blk_valid=0, req_ready=1, err_flag=0.
  - Subsequent read works.

Source files
------------

// File: rtl/sd_line_bridge.sv
// rtl/sd_line_bridge.sv - cache-line to SD block bridge with retry and sticky error
module sd_line_bridge #(
    parameter int ADDR    = 32,
    parameter int CMD     = 1,
    parameter int WIDTH   = 4096,
    parameter int RETRIES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ADDR-1:0]  req_addr,
    input  logic [WIDTH-1:0] req_data,
    input  logic [CMD-1:0]   req_cmd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [ADDR-1:0]  blk_addr,
    output logic             blk_wr,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [7:0]       wr_byte,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [7:0]       rd_byte,
    input  logic             blk_done,
    input  logic             blk_err,
    output logic             err_flag
);

    localparam int NBYTES = WIDTH / 8;
    localparam int OFFSET = $clog2(NBYTES);
    localparam int CW     = (OFFSET > 0) ? OFFSET : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WR_STREAM = 3'd2,
        S_RD_STREAM = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESPOND   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] buffer;
    logic [CW-1:0]    count;
    logic [2:0]       retry_cnt;

    logic req_fire;
    logic blk_fire;
    logic wr_fire;
    logic rd_fire;
    logic streaming;
    logic last_byte;
    logic fail;
    logic can_retry;

    // Handshake and failure qualifiers shared by the FSM and the datapath
    always_comb begin
        req_fire  = req_valid & req_ready;
        blk_fire  = blk_valid & blk_ready;
        wr_fire   = wr_valid & wr_ready;
        rd_fire   = rd_valid & rd_ready;
        streaming = (state == S_WR_STREAM) || (state == S_RD_STREAM);
        last_byte = (count == CW'(NBYTES - 1));
        // An early end of block while streaming is a failure even without blk_err
        fail      = (streaming & blk_done) | ((state == S_WAIT_DONE) & blk_done & blk_err);
        can_retry = (retry_cnt < 3'(RETRIES));
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_fire) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (blk_fire) state_next = blk_wr ? S_WR_STREAM : S_RD_STREAM;
            end
            S_WR_STREAM: begin
                if (!blk_done && wr_fire && last_byte) state_next = S_WAIT_DONE;
            end
            S_RD_STREAM: begin
                if (!blk_done && rd_fire && last_byte) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (blk_done && !blk_err) state_next = blk_wr ? S_IDLE : S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Failed block: reissue while retries remain, otherwise give up
        if (fail) begin
            if (can_retry) state_next = S_ISSUE;
            else           state_next = blk_wr ? S_IDLE : S_RESPOND;
        end
    end

    // Output decode; streaming strobes drop the same cycle an early blk_done arrives
    always_comb begin
        req_ready = (state == S_IDLE);
        blk_valid = (state == S_ISSUE);
        wr_valid  = (state == S_WR_STREAM) & ~blk_done;
        rd_ready  = (state == S_RD_STREAM) & ~blk_done;
        rsp_valid = (state == S_RESPOND);
        wr_byte   = buffer[{count, 3'b000} +: 8];
    end

    // Request latch, byte counter, line buffer, retry counter and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            blk_addr  <= '0;
            blk_wr    <= 1'b0;
            buffer    <= '0;
            rsp_data  <= '0;
            count     <= '0;
            retry_cnt <= '0;
            err_flag  <= 1'b0;
        end else begin
            if (req_fire) begin
                blk_addr  <= req_addr >> OFFSET;
                blk_wr    <= req_cmd[0];
                retry_cnt <= '0;
                if (req_cmd[0]) buffer <= req_data;
            end
            if (blk_fire) count <= '0;
            if (wr_fire) count <= count + CW'(1);
            if (rd_fire) begin
                buffer[{count, 3'b000} +: 8] <= rd_byte;
                count                        <= count + CW'(1);
            end
            if (fail) begin
                if (can_retry) retry_cnt <= retry_cnt + 3'd1;
                else           err_flag  <= 1'b1;
            end
            // Snapshot the line on entry so it stays stable while the cache stalls
            if ((state_next == S_RESPOND) && (state != S_RESPOND)) rsp_data <= buffer;
        end
    end

endmodule

// File: tb/tb_sd_line_bridge.sv
// tb/tb_sd_line_bridge.sv - directed self-checking bench for sd_line_bridge
module tb_sd_line_bridge;

    localparam int WIDTH  = 4096;
    localparam int NBYTES = WIDTH / 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_addr = '0;
    logic [WIDTH-1:0] req_data = '0;
    logic [0:0]       req_cmd = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             blk_valid;
    logic             blk_ready = 1'b0;
    logic [31:0]      blk_addr;
    logic             blk_wr;
    logic             wr_valid;
    logic             wr_ready = 1'b0;
    logic [7:0]       wr_byte;
    logic             rd_valid = 1'b0;
    logic             rd_ready;
    logic [7:0]       rd_byte = '0;
    logic             blk_done = 1'b0;
    logic             blk_err = 1'b0;
    logic             err_flag;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int c_req = 0;
    int t_rsp = 0;
    int blk_count = 0;
    int blk_base = 0;
    logic [7:0]       eng_rd [NBYTES];
    logic [WIDTH-1:0] exp_line;

    sd_line_bridge #(.ADDR(32), .CMD(1), .WIDTH(WIDTH), .RETRIES(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_cmd(req_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_addr(blk_addr), .blk_wr(blk_wr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_byte(wr_byte),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_byte(rd_byte),
        .blk_done(blk_done), .blk_err(blk_err), .err_flag(err_flag)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic cmd, input logic [WIDTH-1:0] data);
        int n;
        for (n = 0; n < 2000 && !req_ready; n++) @(negedge clock);
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_cmd   = cmd;
        req_data  = data;
        c_req     = cyc;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic engine_accept(input logic [31:0] exp_addr, input logic exp_wr);
        int n;
        for (n = 0; n < 2000 && !blk_valid; n++) @(negedge clock);
        chk("blk_valid_wait", blk_valid, 1);
        chk("blk_addr", blk_addr, exp_addr);
        chk("blk_wr", blk_wr, exp_wr);
        blk_ready = 1'b1;
        @(negedge clock);
        blk_ready = 1'b0;
        blk_count++;
    endtask

    task automatic engine_read(input int stop_at);
        int bad = 0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i == stop_at) break;
            if (rd_ready !== 1'b1) bad++;
            rd_valid = 1'b1;
            rd_byte  = eng_rd[i];
            @(negedge clock);
        end
        rd_valid = 1'b0;
        chk("rd_ready_held", bad, 0);
    endtask

    task automatic engine_write(input int stop_at, input bit toggle);
        int bad = 0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i == stop_at) break;
            if (toggle) begin
                wr_ready = 1'b0;
                if (wr_valid !== 1'b1 || wr_byte !== exp_line[8*i +: 8]) bad++;
                @(negedge clock);
            end
            wr_ready = 1'b1;
            if (wr_valid !== 1'b1 || wr_byte !== exp_line[8*i +: 8]) bad++;
            @(negedge clock);
        end
        wr_ready = 1'b0;
        chk("wr_bytes", bad, 0);
    endtask

    task automatic engine_done(input logic err);
        blk_done = 1'b1;
        blk_err  = err;
        @(negedge clock);
        blk_done = 1'b0;
        blk_err  = 1'b0;
    endtask

    task automatic finish_read(input logic exp_err, input int hold);
        int n;
        int bad = 0;
        logic [WIDTH-1:0] snap;
        for (n = 0; n < 2000 && !rsp_valid; n++) @(negedge clock);
        t_rsp = cyc;
        chk("rsp_valid_wait", rsp_valid, 1);
        for (int i = 0; i < NBYTES; i++)
            if (rsp_data[8*i +: 8] !== exp_line[8*i +: 8]) bad++;
        chk("rsp_data_bytes", bad, 0);
        chk("err_flag_rsp", err_flag, exp_err);
        snap = rsp_data;
        bad  = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_data !== snap || req_ready !== 1'b0) bad++;
        end
        chk("rsp_stall_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("req_ready_after_rsp", req_ready, 1);
        chk("rsp_valid_after_rsp", rsp_valid, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        chk("rst_req_ready", req_ready, 1);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_blk_addr", blk_addr, 0);
        chk("rst_blk_wr", blk_wr, 0);
        chk("rst_rsp_data", (rsp_data === '0), 1);

        // Stray failed blk_done in IDLE is ignored
        engine_done(1'b1);
        chk("idle_done_ignored_rdy", req_ready, 1);
        chk("idle_done_ignored_err", err_flag, 0);

        // Clean read, bytes i mod 256, minimum latency
        for (int i = 0; i < NBYTES; i++) begin
            eng_rd[i] = 8'(i);
            exp_line[8*i +: 8] = 8'(i);
        end
        send_req(32'h0000_0400, 1'b0, '0);
        engine_accept(32'd2, 1'b0);
        engine_read(-1);
        engine_done(1'b0);
        finish_read(1'b0, 0);
        chk("read_latency", t_rsp - c_req, 515);

        // Write with wr_ready toggling, bytes ~i
        for (int i = 0; i < NBYTES; i++) exp_line[8*i +: 8] = ~8'(i);
        send_req(32'h0000_0600, 1'b1, exp_line);
        engine_accept(32'd3, 1'b1);
        engine_write(-1, 1'b1);
        chk("wr_wait_req_ready", req_ready, 0);
        engine_done(1'b0);
        chk("wr_done_req_ready", req_ready, 1);
        chk("wr_no_rsp", rsp_valid, 0);
        chk("wr_err_flag", err_flag, 0);

        // Read, first attempt fails, second clean; unaligned low bits ignored; stalled response
        blk_base = blk_count;
        for (int i = 0; i < NBYTES; i++) eng_rd[i] = 8'h55;
        send_req(32'h0000_0A1F, 1'b0, '0);
        engine_accept(32'd5, 1'b0);
        engine_read(-1);
        engine_done(1'b1);
        for (int i = 0; i < NBYTES; i++) begin
            eng_rd[i] = 8'(i * 3 + 7);
            exp_line[8*i +: 8] = 8'(i * 3 + 7);
        end
        engine_accept(32'd5, 1'b0);
        engine_read(-1);
        engine_done(1'b0);
        finish_read(1'b0, 10);
        chk("retry_blk_count", blk_count - blk_base, 2);

        // Early clean blk_done at byte 100 counts as failure and retries
        blk_base = blk_count;
        for (int i = 0; i < NBYTES; i++) eng_rd[i] = 8'h11;
        send_req(32'h0000_2000, 1'b0, '0);
        engine_accept(32'd16, 1'b0);
        engine_read(100);
        engine_done(1'b0);
        chk("early_rd_ready_low", rd_ready, 0);
        for (int i = 0; i < NBYTES; i++) begin
            eng_rd[i] = 8'(i) ^ 8'hA5;
            exp_line[8*i +: 8] = 8'(i) ^ 8'hA5;
        end
        engine_accept(32'd16, 1'b0);
        engine_read(-1);
        engine_done(1'b0);
        finish_read(1'b0, 0);
        chk("early_blk_count", blk_count - blk_base, 2);

        // Write failing three times exhausts retries
        blk_base = blk_count;
        for (int i = 0; i < NBYTES; i++) exp_line[8*i +: 8] = 8'(i + 40);
        send_req(32'h0000_0800, 1'b1, exp_line);
        for (int a = 0; a < 3; a++) begin
            engine_accept(32'd4, 1'b1);
            engine_write(-1, 1'b0);
            if (a == 1) chk("err_before_last", err_flag, 0);
            engine_done(1'b1);
        end
        chk("fail_blk_count", blk_count - blk_base, 3);
        chk("fail_err_flag", err_flag, 1);
        chk("fail_req_ready", req_ready, 1);
        repeat (3) @(negedge clock);
        chk("fail_no_reissue", blk_valid, 0);
        chk("fail_no_rsp", rsp_valid, 0);

        // Following read completes with sticky err_flag
        for (int i = 0; i < NBYTES; i++) begin
            eng_rd[i] = 8'(255 - i);
            exp_line[8*i +: 8] = 8'(255 - i);
        end
        send_req(32'h0000_0400, 1'b0, '0);
        engine_accept(32'd2, 1'b0);
        engine_read(-1);
        engine_done(1'b0);
        finish_read(1'b1, 0);

        // Reset at byte 200 of a write
        for (int i = 0; i < NBYTES; i++) exp_line[8*i +: 8] = 8'(i * 7);
        send_req(32'h0000_0C00, 1'b1, exp_line);
        engine_accept(32'd6, 1'b1);
        engine_write(200, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_wr_valid", wr_valid, 0);
        chk("rst_mid_blk_valid", blk_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_err_flag", err_flag, 0);
        reset = 1'b0;
        @(negedge clock);

        // Read after reset
        for (int i = 0; i < NBYTES; i++) begin
            eng_rd[i] = 8'(i) ^ 8'h3C;
            exp_line[8*i +: 8] = 8'(i) ^ 8'h3C;
        end
        send_req(32'h0000_1200, 1'b0, '0);
        engine_accept(32'd9, 1'b0);
        engine_read(-1);
        engine_done(1'b0);
        finish_read(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
